// File: rtl/clksel_req.sv
// clksel_req: CPU clock-source arbiter.
// Decides per CPU access whether the core may run on the fast HS clock or
// has to drop to the host LS (PHI2) clock. It requests a switch from the
// external clock controller and waits for that controller's asynchronous
// feedback. It abandons a switch that never settles and reports it with a
// one-cycle error pulse.
//
// Handshake: req_valid/req_addr are held stable by the requester until
// accepted. A transfer happens on a rising hsclk_in edge where
// req_valid & req_ready. req_ready is a combinational function of
// registered state, turbo, req_valid and req_addr only, and never of
// req_ready itself.
//
// state_o encoding: 0 WAIT_LS, 1 RUN_LS, 2 SW_TO_HS, 3 RUN_HS, 4 SW_TO_LS.
module clksel_req #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned LS_HOLD     = 16
) (
    input  logic        hsclk_in,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_wdata,
    output logic        hsclk_sel,
    output logic [1:0]  cpuclk_div_sel,
    input  logic        hsclk_selected,
    input  logic        lsclk_selected,
    output logic        switch_err,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        WAIT_LS  = 3'd0,
        RUN_LS   = 3'd1,
        SW_TO_HS = 3'd2,
        RUN_HS   = 3'd3,
        SW_TO_LS = 3'd4
    } state_t;

    localparam int unsigned       HOLD_W   = $clog2(LS_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LS_HOLD);
    localparam logic [7:0]        TO_MAX   = 8'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
    logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [7:0]             to_cnt_q, to_cnt_d;
    logic                   turbo_q, turbo_d;
    logic [1:0]             div_pend_q, div_pend_d;
    logic [1:0]             div_sel_q, div_sel_d;
    logic                   hsclk_sel_q, hsclk_sel_d;

    logic hs_s;
    logic ls_s;
    logic need_ls;
    logic accept;
    logic in_switch;

    // Feedback synchronisers: shift each raw feedback bit in at stage 0.
    always_comb begin
        hs_sync_d = (hs_sync_q << 1) | SYNC_STAGES'(hsclk_selected);
        ls_sync_d = (ls_sync_q << 1) | SYNC_STAGES'(lsclk_selected);
    end

    // Only the last synchroniser stage is ever read by the control logic.
    assign hs_s = hs_sync_q[SYNC_STAGES-1];
    assign ls_s = ls_sync_q[SYNC_STAGES-1];

    // Classify the pending access: host-owned windows, or turbo off, need LS.
    always_comb begin
        need_ls = 1'b0;
        if (req_addr[23:16] == 8'hFF) begin
            need_ls = 1'b1;
        end
        if ((req_addr[23:16] == 8'h00) &&
            (req_addr[15:0] >= 16'hFC00) && (req_addr[15:0] <= 16'hFEFF)) begin
            need_ls = 1'b1;
        end
        if (!turbo_q) begin
            need_ls = 1'b1;
        end
    end

    // FSM next state plus the combinational handshake and error outputs.
    // When feedback settles in the same cycle the timeout expires, the
    // completed switch wins and no error is raised.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        switch_err = 1'b0;
        case (state_q)
            WAIT_LS: begin
                if (ls_s && !hs_s) begin
                    state_d = RUN_LS;
                end
            end
            RUN_LS: begin
                req_ready = req_valid && need_ls;
                if (req_valid && !need_ls && (hold_cnt_q == HOLD_MAX)) begin
                    state_d = SW_TO_HS;
                end
            end
            SW_TO_HS: begin
                if (hs_s && !ls_s) begin
                    state_d = RUN_HS;
                end else if (to_cnt_q == TO_MAX) begin
                    state_d    = WAIT_LS;
                    switch_err = 1'b1;
                end
            end
            RUN_HS: begin
                req_ready = req_valid && !need_ls;
                if (req_valid && need_ls) begin
                    state_d = SW_TO_LS;
                end
            end
            SW_TO_LS: begin
                if (ls_s && !hs_s) begin
                    state_d = WAIT_LS;
                end else if (to_cnt_q == TO_MAX) begin
                    state_d    = WAIT_LS;
                    switch_err = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LS;
            end
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign in_switch = (state_q == SW_TO_HS) || (state_q == SW_TO_LS);

    // Counters, configuration and the registered clock-controller outputs.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = 8'd0;
        turbo_d     = turbo_q;
        div_pend_d  = div_pend_q;
        div_sel_d   = div_sel_q;
        hsclk_sel_d = (state_d == SW_TO_HS) || (state_d == RUN_HS);

        // LS dwell counter: restarts on arrival in RUN_LS and after every
        // LS transfer, and saturates so the HS return gate stays open.
        if ((state_q == WAIT_LS) && (state_d == RUN_LS)) begin
            hold_cnt_d = '0;
        end else if (state_q == RUN_LS) begin
            if (accept) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q < HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end

        // Switch timeout: counts only while staying in the same switch state;
        // any entry into a switch state starts it again from zero.
        if (in_switch && (state_d == state_q)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end

        if (cfg_we) begin
            turbo_d    = cfg_wdata[0];
            div_pend_d = cfg_wdata[2:1];
        end
        // A failed switch forces LS operation even against a same-cycle write.
        if (switch_err) begin
            turbo_d = 1'b0;
        end

        // The divider only moves while the core is firmly on the LS clock.
        if ((state_q == WAIT_LS) || (state_q == RUN_LS)) begin
            div_sel_d = div_pend_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= WAIT_LS;
            hs_sync_q   <= '0;
            ls_sync_q   <= '0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= 8'd0;
            turbo_q     <= 1'b0;
            div_pend_q  <= 2'b00;
            div_sel_q   <= 2'b00;
            hsclk_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_sync_q   <= hs_sync_d;
            ls_sync_q   <= ls_sync_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            turbo_q     <= turbo_d;
            div_pend_q  <= div_pend_d;
            div_sel_q   <= div_sel_d;
            hsclk_sel_q <= hsclk_sel_d;
        end
    end

    assign hsclk_sel      = hsclk_sel_q;
    assign cpuclk_div_sel = div_sel_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_clksel_req.sv
// tb_clksel_req: directed scenarios followed by randomized traffic against
// an emulated clock controller, all checked against a reference model.
module tb_clksel_req;

  localparam int SYNC = 2;
  localparam int TMO  = 255;
  localparam int HOLD = 16;

  // state_o values as seen on the debug port
  localparam int S_WAIT   = 0;
  localparam int S_RUN_LS = 1;
  localparam int S_SW_HS  = 2;
  localparam int S_RUN_HS = 3;
  localparam int S_SW_LS  = 4;

  logic        hsclk_in = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_ready;
  logic        cfg_we;
  logic [2:0]  cfg_wdata;
  logic        hsclk_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        switch_err;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  // reference model
  int       m_state;
  int       m_hold;
  int       m_to;
  bit       m_sel;
  bit       m_turbo;
  bit [1:0] m_pend;
  bit [1:0] m_div;
  bit       m_last_accept;
  bit       hs_line[$];
  bit       ls_line[$];

  // emulated clock controller
  bit cur_target;
  int fb_delay;
  bit frozen;

  logic [23:0] pool [8];

  clksel_req #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO),
    .LS_HOLD(HOLD)
  ) dut (
    .hsclk_in(hsclk_in),
    .rst_b(rst_b),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .cfg_we(cfg_we),
    .cfg_wdata(cfg_wdata),
    .hsclk_sel(hsclk_sel),
    .cpuclk_div_sel(cpuclk_div_sel),
    .hsclk_selected(hsclk_selected),
    .lsclk_selected(lsclk_selected),
    .switch_err(switch_err),
    .state_o(state_o)
  );

  // clock
  always #5 hsclk_in = ~hsclk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_WAIT;
    m_hold = 0;
    m_to = 0;
    m_sel = 0;
    m_turbo = 0;
    m_pend = 2'b00;
    m_div = 2'b00;
    m_last_accept = 0;
    hs_line.delete();
    ls_line.delete();
    for (int i = 0; i < SYNC; i++) begin
      hs_line.push_back(1'b0);
      ls_line.push_back(1'b0);
    end
  endtask

  // LS is needed for the host bank, the host I/O window of bank 0, or turbo off
  function automatic bit need_ls_f(input logic [23:0] a);
    int bank;
    int off;
    bank = int'(a >> 16);
    off = int'(a & 24'h00FFFF);
    return (bank == 255) || (bank == 0 && off >= 'hFC00 && off <= 'hFEFF) || !m_turbo;
  endfunction

  function automatic bit m_hs();
    return hs_line[SYNC-1];
  endfunction

  function automatic bit m_ls();
    return ls_line[SYNC-1];
  endfunction

  function automatic bit m_ready();
    bit need;
    need = need_ls_f(req_addr);
    return (req_valid === 1'b1) &&
           ((m_state == S_RUN_LS && need) || (m_state == S_RUN_HS && !need));
  endfunction

  function automatic bit m_err();
    bit settled;
    settled = (m_state == S_SW_HS) ? (m_hs() && !m_ls()) : (m_ls() && !m_hs());
    return (m_state == S_SW_HS || m_state == S_SW_LS) && !settled && (m_to == TMO);
  endfunction

  // advance the model by one rising edge, from the inputs present at that edge
  task automatic model_edge();
    bit hs;
    bit ls;
    bit rdy;
    bit err;
    bit need;
    int nxt;
    if (rst_b !== 1'b1) begin
      model_reset();
      return;
    end
    hs = m_hs();
    ls = m_ls();
    rdy = m_ready();
    err = m_err();
    need = need_ls_f(req_addr);
    m_last_accept = rdy;
    nxt = m_state;
    case (m_state)
      S_WAIT:   if (ls && !hs) nxt = S_RUN_LS;
      S_RUN_LS: if (req_valid && !need && m_hold == HOLD) nxt = S_SW_HS;
      S_RUN_HS: if (req_valid && need) nxt = S_SW_LS;
      S_SW_HS:  if (hs && !ls) nxt = S_RUN_HS; else if (err) nxt = S_WAIT;
      S_SW_LS:  if ((ls && !hs) || err) nxt = S_WAIT;
      default:  nxt = S_WAIT;
    endcase
    if (m_state == S_WAIT && nxt == S_RUN_LS) m_hold = 0;
    else if (m_state == S_RUN_LS) m_hold = rdy ? 0 : ((m_hold < HOLD) ? m_hold + 1 : HOLD);
    m_to = ((m_state == S_SW_HS || m_state == S_SW_LS) && nxt == m_state) ? m_to + 1 : 0;
    if (m_state == S_WAIT || m_state == S_RUN_LS) m_div = m_pend;
    if (cfg_we) m_pend = cfg_wdata[2:1];
    if (err) m_turbo = 0;
    else if (cfg_we) m_turbo = cfg_wdata[0];
    m_sel = (nxt == S_SW_HS || nxt == S_RUN_HS);
    m_state = nxt;
    hs_line.push_front(hsclk_selected);
    ls_line.push_front(lsclk_selected);
    void'(hs_line.pop_back());
    void'(ls_line.pop_back());
  endtask

  // compare on the falling edge, update the model on the rising edge,
  // return 1 time unit later so the caller can drive the next inputs
  task automatic cycle();
    @(negedge hsclk_in);
    check("req_ready", req_ready, m_ready());
    check("hsclk_sel", hsclk_sel, m_sel);
    check("div_sel", cpuclk_div_sel, m_div);
    check("switch_err", switch_err, m_err());
    check("state", state_o, m_state);
    @(posedge hsclk_in);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic v, input logic [23:0] a);
    req_valid = v;
    req_addr = a;
  endtask

  task automatic set_fb(input logic hs, input logic ls);
    hsclk_selected = hs;
    lsclk_selected = ls;
  endtask

  initial begin
    pool[0] = 24'h00FE40; pool[1] = 24'hFF1234; pool[2] = 24'h012000; pool[3] = 24'h00FC00;
    pool[4] = 24'h00FEFF; pool[5] = 24'h00FF00; pool[6] = 24'h00FBFF; pool[7] = 24'h7F8000;

    // reset with LS already reported by the controller
    rst_b = 1'b0;
    cfg_we = 1'b0;
    cfg_wdata = 3'b000;
    set_req(1'b0, 24'h0);
    set_fb(1'b0, 1'b1);
    model_reset();
    repeat (3) cycle();
    #2;
    check("rst_state", state_o, S_WAIT);
    check("rst_sel", hsclk_sel, 0);
    check("rst_err", switch_err, 0);
    rst_b = 1'b1;

    // RUN_LS three edges after release, first LS request accepted at once
    cycle();
    cycle();
    #2 check("still_wait", state_o, S_WAIT);
    cycle();
    #2 check("run_ls_after_3", state_o, S_RUN_LS);
    set_req(1'b1, 24'h00FE40);
    #1 check("ls_first_ready", req_ready, 1);
    cycle();
    set_req(1'b0, 24'h0);

    // turbo on, idle dwell, then an HS request
    cfg_we = 1'b1;
    cfg_wdata = 3'b001;
    cycle();
    cfg_we = 1'b0;
    repeat (20) cycle();
    set_req(1'b1, 24'h012000);
    #1 check("hs_req_not_ready", req_ready, 0);
    cycle();
    #1 check("hs_sel_rise", hsclk_sel, 1);
    check("sw_to_hs", state_o, S_SW_HS);
    set_fb(1'b1, 1'b0);
    cycle();
    cycle();
    #1 check("hs_not_yet", req_ready, 0);
    cycle();
    #1 check("hs_ready_3", req_ready, 1);
    cycle();
    set_req(1'b0, 24'h0);

    // divider write in RUN_HS waits for WAIT_LS
    cfg_we = 1'b1;
    cfg_wdata = 3'b011;
    cycle();
    cfg_we = 1'b0;
    repeat (5) cycle();
    #1 check("div_frozen_hs", cpuclk_div_sel, 0);
    set_req(1'b1, 24'hFF0000);
    cycle();
    #1 check("ls_sel_fall", hsclk_sel, 0);
    check("sw_to_ls", state_o, S_SW_LS);
    set_fb(1'b0, 1'b1);
    repeat (3) cycle();
    #1 check("wait_ls_entry", state_o, S_WAIT);
    check("div_still_00", cpuclk_div_sel, 0);
    cycle();
    #1 check("div_now_01", cpuclk_div_sel, 1);
    check("ls_req_ready", req_ready, 1);
    cycle();

    // HS request right after an LS transfer is held off by the dwell counter
    set_req(1'b1, 24'h012000);
    for (int i = 0; i < HOLD; i++) begin
      #1 check("hold_blocked", req_ready, 0);
      cycle();
    end
    #1 check("hold_still_ls", state_o, S_RUN_LS);
    cycle();
    #1 check("hold_done_sw", state_o, S_SW_HS);

    // feedback stays on LS: timeout, with a cfg write on the same cycle
    for (int n = 0; n < 300; n++) begin
      if (m_state == S_SW_HS && m_to == TMO) break;
      cycle();
    end
    cfg_we = 1'b1;
    cfg_wdata = 3'b101;
    #1 check("timeout_err", switch_err, 1);
    cycle();
    cfg_we = 1'b0;
    #1 check("timeout_wait", state_o, S_WAIT);
    check("timeout_sel", hsclk_sel, 0);
    check("err_one_cycle", switch_err, 0);
    cycle();
    #1 check("turbo_cleared", req_ready, 1);
    cycle();
    set_req(1'b0, 24'h0);

    // reset in the middle of an HS->LS switch
    cfg_we = 1'b1;
    cfg_wdata = 3'b001;
    cycle();
    cfg_we = 1'b0;
    repeat (17) cycle();
    set_req(1'b1, 24'h012000);
    cycle();
    set_fb(1'b1, 1'b0);
    repeat (4) cycle();
    set_req(1'b1, 24'hFF0000);
    cycle();
    set_fb(1'b1, 1'b1);
    repeat (5) cycle();
    check("pre_rst_sw_ls", state_o, S_SW_LS);
    rst_b = 1'b0;
    #1;
    check("arst_state", state_o, S_WAIT);
    check("arst_sel", hsclk_sel, 0);
    check("arst_ready", req_ready, 0);
    check("arst_div", cpuclk_div_sel, 0);
    check("arst_err", switch_err, 0);
    model_reset();
    repeat (3) cycle();
    set_fb(1'b0, 1'b1);
    set_req(1'b0, 24'h0);
    rst_b = 1'b1;

    // randomized traffic with an emulated clock controller
    cur_target = 1'b0;
    fb_delay = 0;
    frozen = 1'b0;
    for (int it = 0; it < 4000; it++) begin
      if (m_sel != cur_target) begin
        cur_target = m_sel;
        if ($urandom_range(0, 1) == 0) set_fb(1'b0, 1'b0);
        else set_fb(1'b1, 1'b1);
        fb_delay = $urandom_range(1, 6);
        frozen = ($urandom_range(0, 9) == 0);
      end else begin
        if (frozen && m_state == S_WAIT) frozen = 1'b0;
        if (fb_delay > 0 && !frozen) begin
          fb_delay--;
          if (fb_delay == 0) set_fb(cur_target, !cur_target);
        end
      end
      if (!req_valid || m_last_accept) begin
        if ($urandom_range(0, 1) == 0) begin
          if ($urandom_range(0, 3) == 0) set_req(1'b1, 24'($urandom));
          else set_req(1'b1, pool[$urandom_range(0, 7)]);
        end else begin
          set_req(1'b0, 24'($urandom));
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        cfg_we = 1'b1;
        cfg_wdata = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
      end else begin
        cfg_we = 1'b0;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clksel_req.md
CLKSEL_REQ -- requirements
Module: clksel_req

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on the clock-select feedback inputs.
REQ-002 Parameter TIMEOUT, default 255: maximum hsclk_in cycles to wait for switch feedback.
REQ-003 Parameter LS_HOLD, default 16: minimum hsclk_in cycles spent on the LS clock before a return to HS is permitted.
REQ-004 hsclk_in  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 rst_b  in  1  asynchronous active-low reset; asserts asynchronously, and deassertion takes effect on the next hsclk_in rising edge.
REQ-006 req_valid  in  1  CPU access request; held stable with req_addr until accepted.
REQ-007 req_addr  in  24  CPU address, {bank[7:0], addr[15:0]}.
REQ-008 req_ready  out  1  access may proceed; a transfer occurs when req_valid & req_ready.
REQ-009 cfg_we  in  1  configuration write strobe.
REQ-010 cfg_wdata  in  3  bit0 turbo enable; bits[2:1] divider select.
REQ-011 hsclk_sel  out  1  request to the clock controller: 1 = HS clock, 0 = LS (host PHI2) clock.
REQ-012 cpuclk_div_sel  out  2  divider select driven to the clock controller.
REQ-013 hsclk_selected, lsclk_selected  in  1 each  asynchronous feedback from the clock controller.
REQ-014 switch_err  out  1  one-cycle pulse on a switch timeout.
REQ-015 state_o  out  3  current FSM state encoding, for debug.

Function
REQ-016 Feedback inputs SHALL each pass through a SYNC_STAGES flip-flop synchroniser; all uses SHALL read only the synchronised copies hs_s and ls_s.
REQ-017 need_ls SHALL equal 1 when bank==8'hFF, or bank==8'h00 and addr in 16'hFC00-16'hFEFF, or turbo==0; need_ls SHALL be 0 otherwise.
REQ-018 FSM states: WAIT_LS, RUN_LS, SW_TO_HS, RUN_HS, SW_TO_LS.
REQ-019 hsclk_sel SHALL be registered and equal to 1 exactly in states SW_TO_HS and RUN_HS.
REQ-020 WAIT_LS: when ls_s & !hs_s, the FSM SHALL move to RUN_LS and clear hold_cnt.
REQ-021 RUN_LS: req_ready = req_valid & need_ls. hold_cnt SHALL saturate at LS_HOLD and clear on each accepted transfer. The FSM SHALL move to SW_TO_HS when req_valid & !need_ls & hold_cnt==LS_HOLD.
REQ-022 RUN_HS: req_ready = req_valid & !need_ls. The FSM SHALL move to SW_TO_LS when req_valid & need_ls.
REQ-023 SW_TO_HS exits to RUN_HS on hs_s & !ls_s; SW_TO_LS exits to WAIT_LS on ls_s & !hs_s, without further waiting. req_ready SHALL be 0 in WAIT_LS, SW_TO_HS and SW_TO_LS.
REQ-024 to_cnt (8 bits) SHALL clear on entry to either SW_ state and increment each cycle in it. When to_cnt==TIMEOUT the block SHALL:
  - pulse switch_err for one cycle;
  - clear turbo;
  - go to WAIT_LS with hsclk_sel=0.
REQ-025 Feedback showing both hs_s and ls_s high, or both low, SHALL be treated as not-yet-settled; only the timeout ends that condition.
REQ-026 A cfg write SHALL update turbo immediately and load div_pend from cfg_wdata[2:1].
REQ-027 cpuclk_div_sel SHALL load div_pend only in WAIT_LS or RUN_LS, and SHALL never change while hsclk_sel==1.
REQ-028 If turbo is cleared while in RUN_HS, need_ls becomes 1, so the next request SHALL cause SW_TO_LS. With no request pending, the FSM SHALL remain in RUN_HS.
REQ-029 A cfg write coinciding with a timeout: the timeout's clearing of turbo SHALL take priority; div_pend SHALL still load.
REQ-030 req_ready SHALL depend combinationally only on registered state, turbo, req_valid and req_addr.

Reset
REQ-031 While rst_b=0 the block SHALL hold:
  - state WAIT_LS;
  - hsclk_sel=0, req_ready=0, switch_err=0;
  - turbo=0, div_pend=2'b00, cpuclk_div_sel=2'b00;
  - hold_cnt=0, to_cnt=0;
  - synchronisers cleared.
REQ-032 Reset asserted mid-switch SHALL abandon the switch immediately, with no switch_err pulse.

Verification
REQ-033 Reset release with lsclk_selected=1, hsclk_selected=0 -> RUN_LS after 3 cycles; request to 0x00FE40 accepted on the first request cycle.
REQ-034 turbo=1, 20 idle LS cycles, request to 0x012000 -> hsclk_sel rises; feedback swapped -> req_ready 3 cycles later; hsclk_sel rises 1 cycle after the request.
REQ-035 In RUN_HS, request to 0xFF0000 -> hsclk_sel=0 next cycle; request accepted in RUN_LS; a subsequent HS request is blocked for 16 cycles (hold_cnt).
REQ-036 SW_TO_HS with feedback frozen -> switch_err pulse after 255 cycles; turbo=0; state WAIT_LS.
REQ-037 cfg write div=2'b01 during RUN_HS -> cpuclk_div_sel stays 00 until entry to WAIT_LS, then becomes 01.
REQ-038 rst_b pulsed low during SW_TO_LS -> all outputs at reset values asynchronously; switch_err stays 0.
